// File: rtl/pbit_pkg.sv
// Shared constants for the p-bit sampler: default widths, tanh LUT scaling,
// saturation bounds and the offline-generated tanh ROM contents.
package pbit_pkg;

  localparam int unsigned IW_DEFAULT    = 8;
  localparam int unsigned RW_DEFAULT    = 8;
  localparam int unsigned CNT_W_DEFAULT = 16;

  // T = round(LUT_OUT_SCALE * tanh(s / LUT_IN_SCALE))
  localparam int LUT_IN_SCALE  = 32;
  localparam int LUT_OUT_SCALE = 127;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  localparam int unsigned TANH_HALF_N = 129;

  // Magnitude half of the 256-entry ROM, indexed by |s| = 0..128; the
  // negative half is recovered by odd symmetry, T(-s) = -T(s).
  localparam logic [6:0] TANH_HALF [TANH_HALF_N] = '{
    7'd0,   7'd4,   7'd8,   7'd12,  7'd16,  7'd20,  7'd24,  7'd27,  7'd31,  7'd35,
    7'd38,  7'd42,  7'd46,  7'd49,  7'd52,  7'd56,  7'd59,  7'd62,  7'd65,  7'd68,
    7'd70,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd87,  7'd89,  7'd91,
    7'd93,  7'd95,  7'd97,  7'd98,  7'd100, 7'd101, 7'd103, 7'd104, 7'd105, 7'd107,
    7'd108, 7'd109, 7'd110, 7'd111, 7'd112, 7'd113, 7'd113, 7'd114, 7'd115, 7'd116,
    7'd116, 7'd117, 7'd118, 7'd118, 7'd119, 7'd119, 7'd120, 7'd120, 7'd120, 7'd121,
    7'd121, 7'd122, 7'd122, 7'd122, 7'd122, 7'd123, 7'd123, 7'd123, 7'd123, 7'd124,
    7'd124, 7'd124, 7'd124, 7'd124, 7'd125, 7'd125, 7'd125, 7'd125, 7'd125, 7'd125,
    7'd125, 7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126,
    7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126,
    7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127,
    7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127,
    7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127
  };

endpackage

// File: rtl/pbit_tanh_lut.sv
// Combinational tanh ROM: signed 8-bit scaled current in, signed 8-bit
// threshold out in [-127, 127].
module pbit_tanh_lut
  import pbit_pkg::*;
(
  input  logic signed [7:0] s,
  output logic signed [7:0] t
);

  logic [7:0] mag;
  logic [6:0] half;

  always_comb begin
    // -(-128) wraps to 8'h80, which reads as 128 unsigned: the last table slot
    mag  = s[7] ? 8'(-s) : 8'(s);
    half = TANH_HALF[mag];
    t    = s[7] ? -$signed({1'b0, half}) : $signed({1'b0, half});
  end

endmodule

// File: rtl/pbit_sampler.sv
// Three-stage p-bit sampler: saturating gain shift, tanh LUT, signed compare
// against a random word, with valid/ready flow control and output statistics.
module pbit_sampler
  import pbit_pkg::*;
#(
  parameter int unsigned IW    = IW_DEFAULT,
  parameter int unsigned RW    = RW_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [IW-1:0] I_in,
  input  logic        [RW-1:0] rand_in,
  input  logic        [1:0]    beta_shift,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_out,
  input  logic                 clr_stats,
  output logic [CNT_W-1:0]     sample_count,
  output logic [CNT_W-1:0]     ones_count
);

  localparam logic signed [IW+2:0] SHL_MAX = (IW+3)'(SAT_MAX);
  localparam logic signed [IW+2:0] SHL_MIN = (IW+3)'(SAT_MIN);

  logic advance;

  logic signed [IW+2:0] i_ext;
  logic signed [IW+2:0] i_shl;
  logic signed [IW-1:0] s_sat;
  logic signed [RW-1:0] r_off;

  logic                 s1_valid_q;
  logic signed [IW-1:0] s1_s_q;
  logic signed [RW-1:0] s1_r_q;

  logic signed [7:0]    lut_t;
  logic                 s2_valid_q;
  logic signed [7:0]    s2_t_q;
  logic signed [RW-1:0] s2_r_q;

  logic                 m_valid_q;
  logic                 m_out_q;

  logic [CNT_W-1:0] sample_d, sample_q;
  logic [CNT_W-1:0] ones_d, ones_q;

  // Whole pipeline moves in lockstep; the output register is the only stall point.
  assign advance  = ~m_valid_q | m_ready;
  assign in_ready = advance;

  always_comb begin
    i_ext = {{3{I_in[IW-1]}}, I_in};
    i_shl = i_ext <<< beta_shift;
    if (i_shl > SHL_MAX) begin
      s_sat = IW'(SAT_MAX);
    end else if (i_shl < SHL_MIN) begin
      s_sat = IW'(SAT_MIN);
    end else begin
      s_sat = i_shl[IW-1:0];
    end
    // Inverting the MSB re-centres the unsigned word onto [-128, 127]
    r_off = {~rand_in[RW-1], rand_in[RW-2:0]};
  end

  pbit_tanh_lut u_lut (
    .s (s1_s_q),
    .t (lut_t)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_s_q     <= '0;
      s1_r_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_t_q     <= '0;
      s2_r_q     <= '0;
      m_valid_q  <= 1'b0;
      m_out_q    <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s1_s_q     <= s_sat;
      s1_r_q     <= r_off;
      s2_valid_q <= s1_valid_q;
      s2_t_q     <= lut_t;
      s2_r_q     <= s1_r_q;
      m_valid_q  <= s2_valid_q;
      m_out_q    <= (s2_t_q > s2_r_q);
    end
  end

  always_comb begin
    sample_d = sample_q;
    ones_d   = ones_q;
    if (clr_stats) begin
      sample_d = '0;
      ones_d   = '0;
    end else if (m_valid_q && m_ready) begin
      if (sample_q != '1) sample_d = sample_q + 1'b1;
      if (m_out_q && (ones_q != '1)) ones_d = ones_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= '0;
      ones_q   <= '0;
    end else begin
      sample_q <= sample_d;
      ones_q   <= ones_d;
    end
  end

  assign m_valid      = m_valid_q;
  assign m_out        = m_out_q;
  assign sample_count = sample_q;
  assign ones_count   = ones_q;

endmodule

// File: tb/tb_pbit_sampler.sv
// Scoreboard bench for pbit_sampler: expected spins are queued at input
// transfer and compared, with latency, at each output transfer.
module tb_pbit_sampler;
  import pbit_pkg::*;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] I_in;
  logic        [7:0] rand_in;
  logic        [1:0] beta_shift;
  logic              m_valid;
  logic              m_ready;
  logic              m_out;
  logic              clr_stats;
  logic       [15:0] sample_count;
  logic       [15:0] ones_count;

  pbit_sampler dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .I_in         (I_in),
    .rand_in      (rand_in),
    .beta_shift   (beta_shift),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_out        (m_out),
    .clr_stats    (clr_stats),
    .sample_count (sample_count),
    .ones_count   (ones_count)
  );

  typedef struct {
    bit m;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_out   = 0;
  int   model_samples = 0;
  int   model_ones    = 0;
  bit   cur_exp   = 0;
  bit   lat_check = 1;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int tanh_ref(input int s);
    int  a;
    int  m;
    real e;
    a = (s < 0) ? -s : s;
    e = $exp(2.0 * a / LUT_IN_SCALE);
    m = $rtoi(LUT_OUT_SCALE * (e - 1.0) / (e + 1.0) + 0.5);
    return (s < 0) ? -m : m;
  endfunction

  function automatic bit m_ref(input int i, input int r, input int b);
    int s;
    s = i * (1 << b);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return tanh_ref(s) > (r - 128);
  endfunction

  // Scoreboard push/pop, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) sb.push_back('{m: cur_exp, cyc: cyc});
      if (m_valid && m_ready) begin
        exp_t e;
        n_out++;
        if (sb.size() == 0) begin
          check("sb_extra_output", m_valid, 0);
        end else begin
          e = sb.pop_front();
          check("m_out", m_out, e.m);
          if (lat_check) check("latency", cyc - e.cyc, 3);
          model_samples++;
          if (e.m) model_ones++;
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic drive(input int i, input int r, input int b, input bit e);
    int budget;
    bit ok;
    I_in       = 8'(i);
    rand_in    = 8'(r);
    beta_shift = 2'(b);
    cur_exp    = e;
    in_valid   = 1'b1;
    budget     = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!ok && budget < 50);
    if (!ok) check("in_ready_timeout", ok, 1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while ((sb.size() != 0 || m_valid) && b < 200) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (b >= 200) check("drain_timeout", b, 0);
  endtask

  task automatic clr_pulse();
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats     = 1'b0;
    model_samples = 0;
    model_ones    = 0;
  endtask

  int d_i[12] = '{0, 0, 127, 127, -128, -128, 100, 100, 32, 32, 16, 16};
  int d_r[12] = '{8'h80, 8'h7F, 8'hFF, 8'hFE, 8'h00, 8'h01, 8'hFF, 8'hFE,
                  8'hE0, 8'hE1, 8'hBA, 8'hBB};
  int d_b[12] = '{0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0, 0};
  bit d_m[12] = '{0, 1, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0};

  int bp_i[6] = '{40, -60, 0, 90, -5, 127};
  int bp_r[6] = '{8'h90, 8'h70, 8'h7F, 8'h10, 8'h85, 8'h01};
  int bp_b[6] = '{0, 1, 0, 2, 3, 0};

  initial begin
    int  t;
    int  n0;
    bit  held;
    bit  xfer;

    rst = 1'b1;
    in_valid = 1'b0;
    I_in = '0;
    rand_in = '0;
    beta_shift = '0;
    m_ready = 1'b1;
    clr_stats = 1'b0;
    #3;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_out", m_out, 0);
    check("rst_samples", sample_count, 0);
    check("rst_ones", ones_count, 0);
    check("rst_in_ready", in_ready, 1);
    #19 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed points, spaced out so each latency is clean
    for (int k = 0; k < 12; k++) begin
      drive(d_i[k], d_r[k], d_b[k], d_m[k]);
      idle();
      repeat (4) begin @(posedge clk); #1; end
    end
    wait_drain();

    // Every LUT entry, right at its threshold from both sides, back to back
    for (int s = -128; s < 128; s++) begin
      t = tanh_ref(s);
      drive(s, t + 128, 0, 1'b0);
      drive(s, t + 127, 0, 1'b1);
    end
    idle();
    wait_drain();

    // Random currents and gains
    for (int k = 0; k < 60; k++) begin
      int ri;
      int rr;
      int rb;
      ri = int'($urandom_range(255)) - 128;
      rr = int'($urandom_range(255));
      rb = int'($urandom_range(3));
      drive(ri, rr, rb, m_ref(ri, rr, rb));
    end
    idle();
    wait_drain();

    // Statistics sweep at I = 0
    clr_pulse();
    for (int r = 0; r < 256; r++) drive(0, r, 0, m_ref(0, r, 0));
    idle();
    wait_drain();
    check("sweep_samples", sample_count, 256);
    check("sweep_ones", ones_count, 128);

    // Clear coincident with an output transfer
    for (int k = 0; k < 4; k++) drive(k * 20, 8'h80, 0, m_ref(k * 20, 8'h80, 0));
    idle();
    clr_stats = 1'b1;
    @(negedge clk);
    xfer = m_valid && m_ready;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    check("clr_with_xfer", xfer, 1);
    check("clr_samples", sample_count, 0);
    check("clr_ones", ones_count, 0);
    wait_drain();

    // Backpressure mid-stream
    clr_pulse();
    lat_check = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++)
          drive(bp_i[k], bp_r[k], bp_b[k], m_ref(bp_i[k], bp_r[k], bp_b[k]));
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        held = m_out;
        check("bp_valid", m_valid, 1);
        repeat (4) begin
          check("bp_in_ready", in_ready, 0);
          check("bp_hold_valid", m_valid, 1);
          check("bp_hold_out", m_out, held);
          @(posedge clk);
          #1;
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_samples", sample_count, 6);
    check("bp_ones", ones_count, model_ones);
    lat_check = 1'b1;

    // Asynchronous reset with samples in flight
    drive(10, 8'h20, 0, m_ref(10, 8'h20, 0));
    drive(-20, 8'h90, 1, m_ref(-20, 8'h90, 1));
    drive(50, 8'hC0, 0, m_ref(50, 8'hC0, 0));
    idle();
    #3;
    rst = 1'b1;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_samples", sample_count, 0);
    check("midrst_ones", ones_count, 0);
    sb.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    n0 = n_out;
    drive(32, 8'hE0, 0, 1'b1);
    idle();
    repeat (10) begin @(posedge clk); #1; end
    check("post_rst_outputs", n_out - n0, 1);
    check("post_rst_samples", sample_count, 1);
    check("post_rst_ones", ones_count, 1);
    check("post_rst_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pbit_sampler.md
Name: pbit_sampler

Overview:
- Consumer end of the RNG path: turns a signed input current plus one random word into a probabilistic bit (p-bit).
- Computes m = +1 with probability ≈ (1 + tanh(beta·I))/2 using a tanh LUT and a comparison against the random word.
- Sits between the synapse/accumulator logic that produces I and the RNG block that produces the 8-bit random words.
- Three-stage pipeline with valid/ready on both sides, plus running output statistics for on-chip calibration.

Parameters:
- IW, 8, width of signed input current I_in.
- RW, 8, width of random word rand_in. Fixed equal to IW in this revision.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  I_in/rand_in present.
- in_ready  out  1  pipeline can accept this cycle.
- I_in  in  IW  signed two's-complement input current.
- rand_in  in  RW  unsigned random word from the RNG.
- beta_shift  in  2  gain exponent (beta = 2^beta_shift); sampled together with I_in.
- m_valid  out  1  sample available.
- m_ready  in  1  downstream accepts sample.
- m_out  out  1  1 = spin +1, 0 = spin −1.
- clr_stats  in  1  synchronous clear of the statistics counters.
- sample_count  out  CNT_W  accepted samples since clear.
- ones_count  out  CNT_W  accepted samples with m_out = 1 since clear.

Behaviour:
- Reset: all stage valids = 0, m_valid = 0, m_out = 0, counters = 0. Reset applies immediately, including mid-pipeline; in-flight data is discarded.
- Stall rule: advance = ~m_valid | m_ready. in_ready = advance. The whole pipeline holds when advance = 0. An input transfer occurs when in_valid & in_ready.
- S1 (capture):
  - s = I_in <<< beta_shift, computed at full width, then saturated to [−128, 127].
  - r = rand_in − 128, i.e. rand_in with the MSB inverted, read as signed.
  - Register s, r and valid.
- S2 (LUT): T = round(127·tanh(s/32)), signed, range [−127, 127]; register T, r and valid.
  - Anchor points: s=0 → 0, s=16 → 59, s=32 → 97, s=−32 → −97, s=127 → 127, s=−128 → −127.
- S3 (decide): m_out = (T > r) as a signed strict compare; m_valid set.
- Latency: 3 clk from input transfer to m_valid under no stall. Throughput: 1 sample/cycle.
- Probability: P(m=1) = (T+128)/256, so I=0 gives exactly 1/2.
- Output hold: m_out and m_valid stay stable while m_valid & ~m_ready.
- Statistics:
  - On each output transfer (m_valid & m_ready), sample_count += 1, and ones_count += 1 if m_out = 1.
  - Both counters saturate at 2^CNT_W − 1. ones_count is always ≤ sample_count.
  - clr_stats in the same cycle as a transfer: the clear wins and both counters read 0 next cycle.
- Pipeline bubbles (in_valid = 0) propagate as valid = 0 and are not counted.

Decomposition:
- Shared package pbit_pkg holds:
  - IW/RW/CNT_W defaults;
  - the LUT input scale constant (32) and output scale constant (127);
  - the saturation bounds;
  - the 256-entry tanh ROM contents, generated offline.
- Sub-module pbit_tanh_lut: combinational 256-entry ROM, signed 8-bit in → signed 8-bit out, instantiated in S2.

Test Plan:
- Latency: I_in=0, beta_shift=0, rand_in=0x80, in_valid for 1 cycle, m_ready=1 → m_valid exactly 3 cycles later with m_out=0 (0 > 0 false). Repeat with rand_in=0x7F → m_out=1.
- Saturation/extremes:
  - I_in=127, rand_in=0xFF → m_out=0; rand_in=0xFE → m_out=1.
  - I_in=−128, rand_in=0x00 → m_out=1; rand_in=0x01 → m_out=0.
  - I_in=100, beta_shift=3 behaves identically to I_in=127.
- LUT points: I_in=32, rand_in=0x80+96 → m_out=1; rand_in=0x80+97 → m_out=0. I_in=16 gives the threshold 59 by the same method.
- Backpressure:
  - Stream 6 inputs back-to-back and hold m_ready=0 for 4 cycles mid-stream → in_ready drops, m_out is held, and all 6 results emerge in order with none lost or duplicated.
  - Counters then read sample_count=6 and ones_count equal to the expected count.
- Statistics: sweep rand_in 0x00..0xFF with I_in=0 → sample_count=256, ones_count=128. Pulse clr_stats coincident with a transfer → both read 0.
- Reset mid-op: assert rst asynchronously with 3 samples in flight → m_valid=0 and counters=0 immediately. After release, the first new input appears after 3 cycles; no stale samples emerge.
